// File: rtl/ballot_pkg.sv
// ballot_pkg
// Shared definitions for the ballot input conditioner.
// Contents:
//   state_t      - FSM states of the ballot front-end (2-bit)
//   NUM_CAND     - number of candidate buttons / outputs
//   BALLOT_CNT_W - width of the accepted-ballot counter
package ballot_pkg;

  typedef enum logic [1:0] {
    LOCKED  = 2'd0,
    ARMED   = 2'd1,
    EMIT    = 2'd2,
    RELEASE = 2'd3
  } state_t;

  localparam int NUM_CAND     = 3;
  localparam int BALLOT_CNT_W = 16;

endpackage

// File: rtl/ballot_input_conditioner_btn_debounce.sv
// btn_debounce
// Two-flop synchroniser followed by a debounce counter for one raw button.
// The debounced level only follows the synchronised level after the two
// have differed for DEBOUNCE_CYCLES consecutive cycles; any return to the
// current level restarts the count.
// Ports:
//   clk   - clock, rising edge
//   rst   - synchronous active-low reset
//   raw   - asynchronous raw button (high = pressed)
//   level - debounced button level
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic             sync1_reg;
  logic             sync2_reg;
  logic             level_reg;
  logic [CNT_W-1:0] cnt_reg;

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync1_reg <= 1'b0;
      sync2_reg <= 1'b0;
      level_reg <= 1'b0;
      cnt_reg   <= '0;
    end else begin
      sync1_reg <= raw;
      sync2_reg <= sync1_reg;
      if (sync2_reg != level_reg) begin
        // Last differing cycle of the window: adopt the new level.
        if (cnt_reg == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
          level_reg <= sync2_reg;
          cnt_reg   <= '0;
        end else begin
          cnt_reg <= cnt_reg + CNT_W'(1);
        end
      end else begin
        cnt_reg <= '0;
      end
    end
  end

  assign level = level_reg;

endmodule

// File: rtl/ballot_input_conditioner.sv
// ballot_input_conditioner
// Debounces three candidate buttons and turns each authorised ballot into
// one fixed-length pulse on exactly one candidate line.
// Optional feature macro: BALLOT_TIMEOUT_EN (armed-state timeout).
// Ports:
//   clk              - clock, rising edge
//   rst              - synchronous active-low reset
//   i_raw_btn[2:0]   - raw candidate buttons, bit0 = candidate 1
//   i_ballot_enable  - officer authorisation, rising edge arms one ballot
//   i_voting_over    - session closed, forces LOCKED
//   o_candidate_1..3 - vote pulses, PULSE_LEN cycles wide
//   o_ballot_ready   - high while armed
//   o_multi_press    - sticky multi-button indication while armed
//   o_ballots_cast   - accepted-vote counter (wraps)
//   o_timeout        - one-cycle pulse on ballot expiry (0 without macro)
module ballot_input_conditioner
  import ballot_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int PULSE_LEN       = 4,
  parameter int TIMEOUT_CYCLES  = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  i_raw_btn,
  input  logic        i_ballot_enable,
  input  logic        i_voting_over,
  output logic        o_candidate_1,
  output logic        o_candidate_2,
  output logic        o_candidate_3,
  output logic        o_ballot_ready,
  output logic        o_multi_press,
  output logic [15:0] o_ballots_cast,
  output logic        o_timeout
);

  localparam int PULSE_W = $clog2(PULSE_LEN + 1);

  logic [NUM_CAND-1:0] btn_db;

  generate
    for (genvar gi = 0; gi < NUM_CAND; gi++) begin : g_db
      btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_db (
        .clk  (clk),
        .rst  (rst),
        .raw  (i_raw_btn[gi]),
        .level(btn_db[gi])
      );
    end
  endgenerate

  state_t                  state_reg, state_next;
  logic                    en_prev_reg, en_edge_reg;
  logic [NUM_CAND-1:0]     choice_reg, choice_next;
  logic [NUM_CAND-1:0]     cand_reg, cand_next;
  logic                    ready_reg, ready_next;
  logic                    multi_reg, multi_next;
  logic [BALLOT_CNT_W-1:0] cast_reg, cast_next;
  logic [PULSE_W-1:0]      pulse_cnt_reg, pulse_cnt_next;
  logic                    any_pressed, one_hot, accept, timeout_hit;

  assign any_pressed = |btn_db;
  assign one_hot     = any_pressed && ((btn_db & (btn_db - NUM_CAND'(1))) == '0);
  // A vote is refused while the multi-press flag is still set, so releasing
  // two buttons one after the other cannot slip a vote through.
  assign accept      = (state_reg == ARMED) && one_hot && !multi_reg;

`ifdef BALLOT_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] to_cnt_reg;
  logic            timeout_reg;

  assign timeout_hit = (state_reg == ARMED) && (to_cnt_reg == TO_W'(TIMEOUT_CYCLES - 1));

  // Counter is held at zero outside ARMED, which clears it on every entry.
  always_ff @(posedge clk) begin
    if (!rst) begin
      to_cnt_reg  <= '0;
      timeout_reg <= 1'b0;
    end else begin
      timeout_reg <= timeout_hit && !accept && !i_voting_over;
      if (state_reg != ARMED) to_cnt_reg <= '0;
      else                    to_cnt_reg <= to_cnt_reg + TO_W'(1);
    end
  end

  assign o_timeout = timeout_reg;
`else
  logic timeout_param_unused;
  assign timeout_param_unused = (TIMEOUT_CYCLES != 0);
  assign timeout_hit          = 1'b0;
  assign o_timeout            = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg     <= LOCKED;
      en_prev_reg   <= 1'b0;
      en_edge_reg   <= 1'b0;
      choice_reg    <= '0;
      cand_reg      <= '0;
      ready_reg     <= 1'b0;
      multi_reg     <= 1'b0;
      cast_reg      <= '0;
      pulse_cnt_reg <= '0;
    end else begin
      state_reg     <= state_next;
      en_prev_reg   <= i_ballot_enable;
      en_edge_reg   <= i_ballot_enable & ~en_prev_reg;
      choice_reg    <= choice_next;
      cand_reg      <= cand_next;
      ready_reg     <= ready_next;
      multi_reg     <= multi_next;
      cast_reg      <= cast_next;
      pulse_cnt_reg <= pulse_cnt_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    choice_next    = choice_reg;
    cast_next      = cast_reg;
    pulse_cnt_next = pulse_cnt_reg;
    multi_next     = multi_reg;

    unique case (state_reg)
      LOCKED: begin
        if (en_edge_reg) state_next = ARMED;
      end
      ARMED: begin
        if (!any_pressed)  multi_next = 1'b0;
        else if (!one_hot) multi_next = 1'b1;
        if (accept) begin
          choice_next    = btn_db;
          cast_next      = cast_reg + BALLOT_CNT_W'(1);
          pulse_cnt_next = '0;
          state_next     = EMIT;
        end else if (timeout_hit) begin
          state_next = LOCKED;
        end
      end
      EMIT: begin
        if (pulse_cnt_reg == PULSE_W'(PULSE_LEN - 1)) state_next = RELEASE;
        else pulse_cnt_next = pulse_cnt_reg + PULSE_W'(1);
      end
      RELEASE: begin
        // Hold until every button is up so a held press cannot vote again.
        if (!any_pressed) state_next = LOCKED;
      end
      default: state_next = LOCKED;
    endcase

    if (i_voting_over) state_next = LOCKED;
    if (state_next != ARMED) multi_next = 1'b0;

    // Outputs are registered from the next state so pulses are glitch-free.
    cand_next  = (state_next == EMIT) ? choice_next : '0;
    ready_next = (state_next == ARMED);
  end

  assign o_candidate_1  = cand_reg[0];
  assign o_candidate_2  = cand_reg[1];
  assign o_candidate_3  = cand_reg[2];
  assign o_ballot_ready = ready_reg;
  assign o_multi_press  = multi_reg;
  assign o_ballots_cast = cast_reg;

endmodule

// File: tb/tb_ballot_input_conditioner.sv
module tb_ballot_input_conditioner;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  raw_btn;
  logic        ballot_enable;
  logic        voting_over;
  logic        cand1, cand2, cand3;
  logic        ready, multi, tmo;
  logic [15:0] cast;

  always #5 clk = ~clk;

  ballot_input_conditioner #(
    .DEBOUNCE_CYCLES(16),
    .PULSE_LEN      (4),
    .TIMEOUT_CYCLES (1024)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .i_raw_btn      (raw_btn),
    .i_ballot_enable(ballot_enable),
    .i_voting_over  (voting_over),
    .o_candidate_1  (cand1),
    .o_candidate_2  (cand2),
    .o_candidate_3  (cand3),
    .o_ballot_ready (ready),
    .o_multi_press  (multi),
    .o_ballots_cast (cast),
    .o_timeout      (tmo)
  );

  typedef struct {
    logic [2:0]  cand;
    logic [15:0] cnt;
    int          width;
  } sb_t;

  typedef struct {
    logic [2:0] btn;
    logic       exp_vote;
    logic       exp_multi;
  } vec_t;

  sb_t        sb_q[$];
  sb_t        cur;
  int         total = 0;
  int         bad = 0;
  logic [2:0] prev_cand = 3'b000;
  int         cur_width = 0;
  logic [15:0] exp_cnt = 16'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Scoreboard monitor, run once per cycle just after the active edge.
  task automatic monitor();
    logic [2:0] v;
    v = {cand3, cand2, cand1};
    check("one_hot_out", ($countones(v) <= 1), 1);
    if (v != 3'b000 && prev_cand == 3'b000) begin
      total++;
      if (sb_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_pulse: got cand=%b, expected none", v);
        cur.width = 0;
      end else begin
        cur = sb_q.pop_front();
        $display("vote pulse cand=%b count=%0d", v, cast);
        if (v !== cur.cand) begin
          bad++;
          $display("FAIL pulse_cand: got %b, expected %b", v, cur.cand);
        end
        check("pulse_count", cast, cur.cnt);
      end
      cur_width = 1;
    end else if (v != 3'b000) begin
      cur_width++;
      check("pulse_stable", v, prev_cand);
    end else if (prev_cand != 3'b000) begin
      check("pulse_width", cur_width, cur.width);
    end
    prev_cand = v;
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
      monitor();
    end
  endtask

  task automatic enable_pulse();
    ballot_enable = 1'b1;
    tick();
    ballot_enable = 1'b0;
    tick();
  endtask

  task automatic expect_vote(input logic [2:0] c, input int w);
    sb_t e;
    exp_cnt++;
    e.cand  = c;
    e.cnt   = exp_cnt;
    e.width = w;
    sb_q.push_back(e);
  endtask

  vec_t vecs[6];

  initial begin
    int n;
    vecs[0] = '{btn: 3'b001, exp_vote: 1'b1, exp_multi: 1'b0};
    vecs[1] = '{btn: 3'b010, exp_vote: 1'b1, exp_multi: 1'b0};
    vecs[2] = '{btn: 3'b100, exp_vote: 1'b1, exp_multi: 1'b0};
    vecs[3] = '{btn: 3'b101, exp_vote: 1'b0, exp_multi: 1'b1};
    vecs[4] = '{btn: 3'b011, exp_vote: 1'b0, exp_multi: 1'b1};
    vecs[5] = '{btn: 3'b111, exp_vote: 1'b0, exp_multi: 1'b1};

    rst = 1'b0; raw_btn = 3'b000; ballot_enable = 1'b0; voting_over = 1'b0;
    tick(3);
    check("rst_cand", {cand3, cand2, cand1}, 0);
    check("rst_ready", ready, 0);
    check("rst_multi", multi, 0);
    check("rst_cast", cast, 0);
    check("rst_timeout", tmo, 0);
    rst = 1'b1;
    tick(2);

    // Single vote with latency and enable-to-ready checks.
    ballot_enable = 1'b1;
    tick();
    ballot_enable = 1'b0;
    check("ready_after_1", ready, 0);
    tick();
    check("ready_after_2", ready, 1);
    raw_btn = 3'b001;
    expect_vote(3'b001, 4);
    n = 0;
    while (n < 60 && !cand1) begin
      tick();
      n++;
    end
    check("press_latency", n, 19);
    tick(40 - n);
    check("vote1_cast", cast, 1);
    raw_btn = 3'b000;
    tick(30);
    check("vote1_locked", ready, 0);

    // Second press with no new authorisation must not vote.
    raw_btn = 3'b001;
    tick(40);
    raw_btn = 3'b000;
    tick(30);
    check("double_vote_cast", cast, exp_cnt);

    // Bounce rejection on button 2.
    enable_pulse();
    for (int t = 0; t < 12; t++) begin
      raw_btn = (t % 2 == 0) ? 3'b010 : 3'b000;
      tick(5);
    end
    check("bounce_cast", cast, exp_cnt);
    raw_btn = 3'b010;
    expect_vote(3'b010, 4);
    tick(40);
    raw_btn = 3'b000;
    tick(30);
    check("bounce_vote_cast", cast, exp_cnt);

    // Table-driven single and multi presses.
    for (int i = 0; i < 6; i++) begin
      enable_pulse();
      raw_btn = vecs[i].btn;
      if (vecs[i].exp_vote) expect_vote(vecs[i].btn, 4);
      tick(40);
      $display("vec %0d btn=%b multi=%b cast=%0d", i, vecs[i].btn, multi, cast);
      check("vec_multi", multi, vecs[i].exp_multi);
      check("vec_cast", cast, exp_cnt);
      check("vec_ready_held", ready, !vecs[i].exp_vote);
      raw_btn = 3'b000;
      tick(30);
      check("vec_multi_clear", multi, 0);
      check("vec_ready_after", ready, !vecs[i].exp_vote);
    end

    // Still armed after the multi-presses: a clean press of button 3 votes.
    raw_btn = 3'b100;
    expect_vote(3'b100, 4);
    tick(40);
    check("multi_then_c3_cast", cast, exp_cnt);
    raw_btn = 3'b000;
    tick(30);
    check("multi_then_c3_locked", ready, 0);

    // Voting over during the second EMIT cycle truncates the pulse.
    enable_pulse();
    raw_btn = 3'b001;
    expect_vote(3'b001, 2);
    n = 0;
    while (n < 60 && !cand1) begin
      tick();
      n++;
    end
    check("vo_pulse_seen", cand1, 1);
    tick();
    voting_over = 1'b1;
    tick();
    check("vo_cut", cand1, 0);
    check("vo_ready", ready, 0);
    check("vo_cast", cast, exp_cnt);
    raw_btn = 3'b000;
    tick(30);
    enable_pulse();
    tick(5);
    check("vo_enable_ignored", ready, 0);
    voting_over = 1'b0;
    tick(5);
    check("vo_not_queued", ready, 0);
    enable_pulse();
    check("rearm_ready", ready, 1);

`ifdef BALLOT_TIMEOUT_EN
    n = 0;
    while (n < 1100 && !tmo) begin
      tick();
      n++;
    end
    check("timeout_cycle", n, 1024);
    check("timeout_ready", ready, 0);
    tick();
    check("timeout_one_cycle", tmo, 0);
    check("timeout_cast", cast, exp_cnt);
`endif

    tick(5);
    check("scoreboard_empty", sb_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
